// File: rtl/riscv_step_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_step_sequencer
//
// Multi-cycle step sequencer for the RISC-V core, replacing the fixed 5-step
// control ring. It holds a one-hot step vector (step 0 = FETCH, step
// NSTAGES-1 = WRITEBACK) and moves to the next step when the current stage
// reports done. Stages the decoder marks in iSkip are jumped over. Passing
// the last active stage returns the sequencer to step 0 and retires the
// instruction.
//
// Each edge does exactly one of these actions, in priority order:
//   reset > flush > timeout > stall > advance > hold
//
// Parameters:
//   NSTAGES   number of steps, at least 2
//   WAIT_MASK bit i = 1: stage i waits for iRdy[i]; 0: stage i takes one cycle
//   TIMEOUT   maximum wait cycles in one waiting stage; 0 turns the watchdog off
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   iClk        clock; all state changes on the rising edge
//   iRst        synchronous active-high reset; overrides every other input
//   iRdy        per-stage ready; only the bit of the current step is used
//   iSkip       per-stage skip request from the decoder; bit 0 is ignored
//   iStall      hold the current step and the wait counter
//   iFlush      abandon the current instruction and return to step 0
//   oStep       one-hot current step (registered)
//   oStepIdx    binary index of the current step (registered)
//   oAdvance    combinational; the step moves forward at the next edge
//   oInstrDone  combinational; this advance wraps back to step 0
//   oTimeout    sticky watchdog error flag, cleared only by reset
//   oRetired    number of completed instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module riscv_step_sequencer #(
  parameter int unsigned          NSTAGES   = 5,
  parameter logic [NSTAGES-1:0]   WAIT_MASK = 5'b01101,
  parameter int unsigned          TIMEOUT   = 255,
  parameter int unsigned          CNT_W     = 32
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic [NSTAGES-1:0]          iRdy,
  input  logic [NSTAGES-1:0]          iSkip,
  input  logic                        iStall,
  input  logic                        iFlush,
  output logic [NSTAGES-1:0]          oStep,
  output logic [$clog2(NSTAGES)-1:0]  oStepIdx,
  output logic                        oAdvance,
  output logic                        oInstrDone,
  output logic                        oTimeout,
  output logic [CNT_W-1:0]            oRetired
);

  localparam int unsigned IDX_W = $clog2(NSTAGES);

  // The wait counter only has to reach TIMEOUT; keep at least one bit so the
  // logic stays well formed when the watchdog is disabled.
  localparam int unsigned WCNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

  localparam logic [NSTAGES-1:0] STEP0 = NSTAGES'(1);

  // The single action taken at the next edge (reset is handled separately
  // because it also clears the sticky flag and the counter).
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_STALL,
    ACT_TIMEOUT,
    ACT_FLUSH
  } act_e;

  logic [WCNT_W-1:0] wait_cnt;
  logic              stage_done;
  logic              stage_waits;
  logic              wd_hit;
  logic [IDX_W-1:0]  nxt_idx;
  act_e              act;

  // Step 0 is always executed, so its skip bit carries no information.
  logic unused_skip0;
  assign unused_skip0 = iSkip[0];

  // oStep is one-hot, so AND-reducing against it selects the current stage's
  // mask and ready bits without a decoder on oStepIdx.
  assign stage_waits = |(oStep & WAIT_MASK);
  assign stage_done  = |(oStep & (~WAIT_MASK | iRdy));

  // The watchdog fires only in a waiting stage that has already waited
  // TIMEOUT cycles and still is not done at this edge.
  assign wd_hit = (TIMEOUT != 0) && stage_waits && (wait_cnt == WCNT_MAX) && !stage_done;

  // Successor: lowest non-skipped stage above the current one, else step 0.
  // Scanning downwards lets the lowest qualifying stage overwrite the others.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    nxt_idx = '0;
    for (int j = NSTAGES - 1; j >= 1; j--) begin
      if (j > int'(oStepIdx) && !iSkip[j]) begin
        nxt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    act = ACT_HOLD;
    if (iFlush) begin
      act = ACT_FLUSH;
    end else if (wd_hit) begin
      act = ACT_TIMEOUT;
    end else if (iStall) begin
      act = ACT_STALL;
    end else if (stage_done) begin
      act = ACT_ADVANCE;
    end
  end

  // A timeout cycle always has stage_done = 0, so it can never look like an
  // advance here.
  assign oAdvance   = (act == ACT_ADVANCE) && !iRst;
  assign oInstrDone = oAdvance && (nxt_idx == '0);

  always_ff @(posedge iClk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (iRst) begin
      // NOTE: the reset is synchronous and covers every register; there is
      // no storage array here that could be left unreset.
      oStep    <= STEP0;
      oStepIdx <= '0;
      wait_cnt <= '0;
      oTimeout <= 1'b0;
      oRetired <= '0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          oStep    <= STEP0;
          oStepIdx <= '0;
          wait_cnt <= '0;
        end
        ACT_TIMEOUT: begin
          oStep    <= STEP0;
          oStepIdx <= '0;
          wait_cnt <= '0;
          oTimeout <= 1'b1;
        end
        ACT_STALL: begin
          // Step and wait counter hold; the watchdog does not count.
        end
        ACT_ADVANCE: begin
          oStep    <= STEP0 << nxt_idx;
          oStepIdx <= nxt_idx;
          wait_cnt <= '0;
          if (nxt_idx == '0) begin
            oRetired <= oRetired + CNT_W'(1);
          end
        end
        default: begin
          // Hold: count waiting cycles, saturating at TIMEOUT.
          if (wait_cnt != WCNT_MAX) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
      endcase
    end
  end

  // The step vector must stay one-hot and agree with the binary index.
  a_step_consistent : assert property (
    @(posedge iClk) disable iff (iRst)
      $onehot(oStep) && (oStep == (STEP0 << oStepIdx))
  );

endmodule

// File: tb/tb_riscv_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riscv_step_sequencer
//
// Three sequencers run side by side:
//   u_dut_a  5 stages, WAIT_MASK 01101, TIMEOUT 4,   CNT_W 4
//   u_dut_c  5 stages, all parameters at their defaults
//   u_dut_b  3 stages, WAIT_MASK 001,   TIMEOUT 255, CNT_W 32
// A and C share one set of inputs; B has its own.
// -----------------------------------------------------------------------------
module tb_riscv_step_sequencer;

  typedef struct {
    int              step;
    int              wcnt;
    bit              tmo;
    longint unsigned retired;
  } mstate_t;

  logic       iClk;
  logic       iRst;
  logic [4:0] rdy, skip;
  logic       stall, flush;
  logic [2:0] rdy_b, skip_b;
  logic       stall_b, flush_b;

  logic [4:0]  step_a;  logic [2:0] idx_a;  logic adv_a, done_a, tmo_a;  logic [3:0]  ret_a;
  logic [4:0]  step_c;  logic [2:0] idx_c;  logic adv_c, done_c, tmo_c;  logic [31:0] ret_c;
  logic [2:0]  step_b;  logic [1:0] idx_b;  logic adv_b, done_b, tmo_b;  logic [31:0] ret_b;

  int checks = 0;
  int errors = 0;

  mstate_t m_a = '{0, 0, 1'b0, 0};
  mstate_t m_b = '{0, 0, 1'b0, 0};
  mstate_t m_c = '{0, 0, 1'b0, 0};
  bit      model_ok = 1'b0;

  riscv_step_sequencer #(
    .NSTAGES(5), .WAIT_MASK(5'b01101), .TIMEOUT(4), .CNT_W(4)
  ) u_dut_a (
    .iClk(iClk), .iRst(iRst), .iRdy(rdy), .iSkip(skip), .iStall(stall), .iFlush(flush),
    .oStep(step_a), .oStepIdx(idx_a), .oAdvance(adv_a), .oInstrDone(done_a),
    .oTimeout(tmo_a), .oRetired(ret_a)
  );

  riscv_step_sequencer u_dut_c (
    .iClk(iClk), .iRst(iRst), .iRdy(rdy), .iSkip(skip), .iStall(stall), .iFlush(flush),
    .oStep(step_c), .oStepIdx(idx_c), .oAdvance(adv_c), .oInstrDone(done_c),
    .oTimeout(tmo_c), .oRetired(ret_c)
  );

  riscv_step_sequencer #(
    .NSTAGES(3), .WAIT_MASK(3'b001), .TIMEOUT(255), .CNT_W(32)
  ) u_dut_b (
    .iClk(iClk), .iRst(iRst), .iRdy(rdy_b), .iSkip(skip_b), .iStall(stall_b), .iFlush(flush_b),
    .oStep(step_b), .oStepIdx(idx_b), .oAdvance(adv_b), .oInstrDone(done_b),
    .oTimeout(tmo_b), .oRetired(ret_b)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: instruction-level rules on plain integers.
  // ---------------------------------------------------------------------------
  function automatic int next_active(input int cur, input int n, input logic [7:0] s);
    for (int j = cur + 1; j < n; j++) begin
      if (!s[j]) return j;
    end
    return 0;
  endfunction

  function automatic bit is_done(input int cur, input logic [7:0] wm, input logic [7:0] r);
    return !wm[cur] || r[cur];
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input int n, input logic [7:0] wm,
                                         input int lim, input logic rst, input logic fl,
                                         input logic st, input logic [7:0] r, input logic [7:0] sk);
    mstate_t nx;
    bit      d;
    int      succ;
    nx   = s;
    d    = is_done(s.step, wm, r);
    succ = next_active(s.step, n, sk);
    if (rst) begin
      nx = '{0, 0, 1'b0, 0};
    end else if (fl) begin
      nx.step = 0;
      nx.wcnt = 0;
    end else if (lim != 0 && wm[s.step] && s.wcnt == lim && !d) begin
      nx.tmo  = 1'b1;
      nx.step = 0;
      nx.wcnt = 0;
    end else if (st) begin
      nx = s;
    end else if (d) begin
      if (succ == 0) nx.retired = s.retired + 1;
      nx.step = succ;
      nx.wcnt = 0;
    end else if (s.wcnt < lim) begin
      nx.wcnt = s.wcnt + 1;
    end
    return nx;
  endfunction

  always @(posedge iClk) begin
    m_a = model_next(m_a, 5, 8'b01101, 4,   iRst, flush,   stall,   {3'b0, rdy},   {3'b0, skip});
    m_c = model_next(m_c, 5, 8'b01101, 255, iRst, flush,   stall,   {3'b0, rdy},   {3'b0, skip});
    m_b = model_next(m_b, 3, 8'b00001, 255, iRst, flush_b, stall_b, {5'b0, rdy_b}, {5'b0, skip_b});
    if (iRst) model_ok = 1'b1;
  end

  task automatic cmp(input string tag, input mstate_t m, input int n, input logic [7:0] wm,
                     input int cw, input logic [7:0] r, input logic [7:0] s,
                     input logic st, input logic fl,
                     input logic [63:0] a_step, input logic [63:0] a_idx,
                     input logic [63:0] a_adv, input logic [63:0] a_done,
                     input logic [63:0] a_tmo, input logic [63:0] a_ret);
    bit          e_adv;
    bit          e_done;
    logic [63:0] mask;
    e_adv  = is_done(m.step, wm, r) && !st && !fl && !iRst;
    e_done = e_adv && (next_active(m.step, n, s) == 0);
    mask   = (cw >= 64) ? '1 : ((64'd1 << cw) - 64'd1);
    check({tag, ".step"},    a_step, 64'd1 << m.step);
    check({tag, ".idx"},     a_idx,  64'(m.step));
    check({tag, ".advance"}, a_adv,  64'(e_adv));
    check({tag, ".done"},    a_done, 64'(e_done));
    check({tag, ".timeout"}, a_tmo,  64'(m.tmo));
    check({tag, ".retired"}, a_ret,  m.retired & mask);
  endtask

  always @(negedge iClk) begin
    if (model_ok) begin
      cmp("A", m_a, 5, 8'b01101, 4,  {3'b0, rdy},   {3'b0, skip},   stall,   flush,
          64'(step_a), 64'(idx_a), 64'(adv_a), 64'(done_a), 64'(tmo_a), 64'(ret_a));
      cmp("C", m_c, 5, 8'b01101, 32, {3'b0, rdy},   {3'b0, skip},   stall,   flush,
          64'(step_c), 64'(idx_c), 64'(adv_c), 64'(done_c), 64'(tmo_c), 64'(ret_c));
      cmp("B", m_b, 3, 8'b00001, 32, {5'b0, rdy_b}, {5'b0, skip_b}, stall_b, flush_b,
          64'(step_b), 64'(idx_b), 64'(adv_b), 64'(done_b), 64'(tmo_b), 64'(ret_b));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    rdy = '0; skip = '0; stall = 1'b0; flush = 1'b0;
    rdy_b = '0; skip_b = '0; stall_b = 1'b0; flush_b = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
  endtask

  // One cycle on the shared 5-stage inputs, pinning step/advance/done of C.
  task automatic step_chk(input logic [4:0] r, input logic [4:0] s, input logic st,
                          input logic fl, input logic [4:0] e_step, input logic e_adv,
                          input logic e_done);
    rdy = r; skip = s; stall = st; flush = fl;
    @(negedge iClk);
    check("seq.step", 64'(step_c), 64'(e_step));
    check("seq.advance", 64'(adv_c), 64'(e_adv));
    check("seq.done", 64'(done_c), 64'(e_done));
    tick();
  endtask

  initial begin
    logic [6:0] pat_b;

    do_reset();
    check("reset.step", 64'(step_c), 64'd1);
    check("reset.idx", 64'(idx_c), 64'd0);
    check("reset.retired", 64'(ret_c), 64'd0);
    check("reset.timeout", 64'(tmo_c), 64'd0);

    // ALU instruction: stage 3 skipped; ready on stage 2 during step 0 is ignored.
    step_chk(5'b00100, 5'b01000, 0, 0, 5'd1,  0, 0);
    step_chk(5'b00100, 5'b01000, 0, 0, 5'd1,  0, 0);
    step_chk(5'b00001, 5'b01000, 0, 0, 5'd1,  1, 0);
    step_chk(5'b00000, 5'b01000, 0, 0, 5'd2,  1, 0);
    step_chk(5'b00000, 5'b01000, 0, 0, 5'd4,  0, 0);
    step_chk(5'b00100, 5'b01000, 0, 0, 5'd4,  1, 0);
    step_chk(5'b00000, 5'b01000, 0, 0, 5'd16, 1, 1);
    check("alu.retired", 64'(ret_c), 64'd1);

    // Load with a 3-cycle stall in step 3.
    step_chk(5'b00001, 5'b00000, 0, 0, 5'd1,  1, 0);
    step_chk(5'b00000, 5'b00000, 0, 0, 5'd2,  1, 0);
    step_chk(5'b00100, 5'b00000, 0, 0, 5'd4,  1, 0);
    step_chk(5'b01000, 5'b00000, 1, 0, 5'd8,  0, 0);
    step_chk(5'b01000, 5'b00000, 1, 0, 5'd8,  0, 0);
    step_chk(5'b01000, 5'b00000, 1, 0, 5'd8,  0, 0);
    step_chk(5'b01000, 5'b00000, 0, 0, 5'd8,  1, 0);
    step_chk(5'b00000, 5'b00000, 0, 0, 5'd16, 1, 1);
    check("load.retired", 64'(ret_c), 64'd2);

    // Flush while in step 2 with its ready high.
    step_chk(5'b00001, 5'b00000, 0, 0, 5'd1, 1, 0);
    step_chk(5'b00000, 5'b00000, 0, 0, 5'd2, 1, 0);
    step_chk(5'b00100, 5'b00000, 0, 1, 5'd4, 0, 0);
    step_chk(5'b00000, 5'b00000, 0, 0, 5'd1, 0, 0);
    check("flush.retired", 64'(ret_c), 64'd2);

    // Watchdog on A: clear the wait counter, then wait 4 cycles plus the firing edge.
    step_chk(5'b00000, 5'b00000, 0, 1, 5'd1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("wd.before", 64'(tmo_a), 64'd0);
      step_chk(5'b00000, 5'b00000, 0, 0, 5'd1, 0, 0);
    end
    check("wd.fired", 64'(tmo_a), 64'd1);
    check("wd.step", 64'(step_a), 64'd1);
    check("wd.other", 64'(tmo_c), 64'd0);
    step_chk(5'b00001, 5'b11110, 0, 0, 5'd1, 1, 1);
    check("wd.sticky", 64'(tmo_a), 64'd1);
    check("wd.retired", 64'(ret_c), 64'd3);

    // Counter wrap on A (4-bit counter) using one-cycle instructions.
    do_reset();
    check("wrap.cleared", 64'(tmo_a), 64'd0);
    for (int i = 0; i < 15; i++) begin
      step_chk(5'b00001, 5'b11110, 0, 0, 5'd1, 1, 1);
    end
    check("wrap.15", 64'(ret_a), 64'd15);
    step_chk(5'b00001, 5'b11110, 0, 0, 5'd1, 1, 1);
    check("wrap.0", 64'(ret_a), 64'd0);
    check("wrap.wide", 64'(ret_c), 64'd16);

    // Set the sticky flag again, then reset in the middle of an instruction.
    for (int i = 0; i < 5; i++) begin
      step_chk(5'b00000, 5'b00000, 0, 0, 5'd1, 0, 0);
    end
    check("rst.tmo_set", 64'(tmo_a), 64'd1);
    step_chk(5'b00001, 5'b00000, 0, 0, 5'd1, 1, 0);
    step_chk(5'b00000, 5'b00000, 0, 0, 5'd2, 1, 0);
    step_chk(5'b00100, 5'b00000, 0, 0, 5'd4, 1, 0);
    iRst = 1'b1;
    step_chk(5'b01000, 5'b00000, 0, 0, 5'd8, 0, 0);
    iRst = 1'b0;
    check("rst.step", 64'(step_a), 64'd1);
    check("rst.retired", 64'(ret_a), 64'd0);
    check("rst.timeout", 64'(tmo_a), 64'd0);

    // 3-stage instance: every stage past 0 skipped, one instruction per ready cycle.
    do_reset();
    skip_b = 3'b110;
    pat_b  = 7'b1101011;
    for (int i = 0; i < 7; i++) begin
      rdy_b = {2'b00, pat_b[i]};
      @(negedge iClk);
      check("p3.step", 64'(step_b), 64'd1);
      check("p3.done", 64'(done_b), 64'(pat_b[i]));
      tick();
    end
    rdy_b = '0;
    check("p3.retired", 64'(ret_b), 64'd5);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_step_sequencer.md
Name: riscv_step_sequencer

Overview:
- Parametrised multi-cycle step sequencer for the RISC-V core. Successor to the fixed 5-step control ring.
- Holds a one-hot step vector of NSTAGES stages. Advances on per-stage ready handshakes.
- Skips stages the current instruction does not need. Supports stall and flush.
- Adds a per-stage wait watchdog and a retired-instruction counter.
- Sits between the instruction decoder (supplies the skip mask) and the datapath, memory and ALU (supply ready, consume step).

Parameters:
- NSTAGES, 5: number of steps (0 = FETCH, NSTAGES-1 = WRITEBACK); minimum 2.
- WAIT_MASK, 5'b01101: bit i = 1 means stage i waits for iRdy[i]; bit i = 0 means stage i lasts exactly one cycle.
- TIMEOUT, 255: maximum wait cycles in a single stage before abort; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  synchronous active-high reset.
- iRdy  in  NSTAGES  per-stage ready; bit i is meaningful only while oStep[i] = 1.
- iSkip  in  NSTAGES  per-stage skip request from the decoder; bit 0 is ignored.
- iStall  in  1  hold the current step (hazard or external stall).
- iFlush  in  1  abandon the current instruction and return to step 0.
- oStep  out  NSTAGES  one-hot current step.
- oStepIdx  out  $clog2(NSTAGES)  binary index of the current step.
- oAdvance  out  1  combinational; high in any cycle where the step changes at the next edge for a normal advance.
- oInstrDone  out  1  combinational; high when advancing from the last active stage back to step 0.
- oTimeout  out  1  sticky watchdog error flag.
- oRetired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (iRst = 1 at an edge):
  - oStep = 1 (step 0), oStepIdx = 0, oTimeout = 0, oRetired = 0, wait counter = 0.
  - Reset overrides every other input.
- Stage completion:
  - done(i) = WAIT_MASK[i] ? iRdy[i] : 1, evaluated for the current step i.
- Next step:
  - nxt = the lowest j with cur < j < NSTAGES and iSkip[j] = 0; if none exists, nxt = 0.
  - When nxt = 0 via this rule, the transition is an instruction completion.
- Per-edge priority: reset > flush > timeout > stall > advance > hold.
  - Flush: step goes to 0; wait counter cleared; oRetired unchanged. Flush while in step 0 keeps step 0 and clears the wait counter.
  - Timeout: if TIMEOUT != 0, the current stage waits (WAIT_MASK = 1), and the wait counter == TIMEOUT with done = 0, then oTimeout is set (sticky until reset), step goes to 0, wait counter is cleared, and oRetired is unchanged.
  - Stall: step and wait counter hold. The watchdog does not count during stall.
  - Advance (done = 1, no stall, no flush): step goes to nxt; wait counter cleared. If this is a completion, oRetired increments by 1 and wraps modulo 2^CNT_W.
  - Hold (done = 0, no stall): wait counter increments, saturating at TIMEOUT.
- oAdvance = done && !iStall && !iFlush && !iRst. It is 0 in a timeout cycle.
- oInstrDone = oAdvance && (nxt == 0).
- Skip mask is sampled combinationally at each advance edge. The decoder must hold it stable from step 1 onward; bits read during step 0 are used only to compute step 0's successor.
- If iSkip has every bit 1..NSTAGES-1 set, step 0 advances directly back to 0: one-cycle instructions, oInstrDone high.
- One-hot invariant: exactly one bit of oStep is set at all times after reset. oStepIdx always matches oStep.
- iRdy bits for non-current stages are ignored. Ready asserted early is not remembered.
- The wait counter is $clog2(TIMEOUT+1) bits wide, minimum 1 bit.

Test Plan:
- ALU instruction: defaults; iSkip = 5'b01000; iRdy[0] high after 2 cycles, iRdy[2] high after 1 cycle -> oStep sequence 1,1,1,2,4,4,16,1; oRetired 0 -> 1; oInstrDone pulses exactly once, on the 16 -> 1 edge.
- Load with stall: iSkip = 0; iStall high for 3 cycles while oStep = 8 and iRdy[3] = 1 -> oStep stays 8 for 3 cycles, oAdvance = 0 during the stall, then 8 -> 16 -> 1; oRetired increments by 1.
- Flush mid-instruction: flush asserted while oStep = 4 with iRdy[2] = 1 -> next oStep = 1; oRetired unchanged; oInstrDone = 0.
- Watchdog: TIMEOUT = 4; hold iRdy[0] = 0 -> after 4 waiting cycles, oTimeout = 1 on the following edge and oStep = 1. oTimeout stays 1 through later instructions until iRst.
- Counter wrap and reset: CNT_W = 4; complete 16 instructions -> oRetired reads 15 then 0. Assert iRst mid-instruction (oStep = 8) -> next edge oStep = 1, oRetired = 0, oTimeout = 0.
- Parametrisation: NSTAGES = 3, WAIT_MASK = 3'b001, iSkip = 3'b110 -> oStep stays 1; oInstrDone high on every cycle with iRdy[0] = 1; oRetired increments by 1 per such cycle.
